// File: rtl/a2d_scan_ctrl.sv
// ADC128S scan sequencer: round-robin background scan plus one-shot reads, two SPI transactions per channel.
// Latency: select+read per channel; a one-shot request waits at most one in-flight channel; SPI waits bounded by TIMEOUT.
module a2d_scan_ctrl #(
  parameter int PAUSE_CYCLES = 64,
  parameter int TIMEOUT      = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [7:0]  ch_mask_i,
  input  logic        req_i,
  input  logic [2:0]  req_ch_i,
  output logic        req_ack_o,
  output logic        req_vld_o,
  output logic [11:0] req_data_o,
  input  logic [2:0]  rd_ch_i,
  output logic [11:0] rd_data_o,
  output logic        rd_fresh_o,
  output logic        scan_done_o,
  output logic        err_o,
  output logic        busy_o,
  output logic [15:0] cmd_o,
  output logic        snd_o,
  input  logic        done_i,
  input  logic [15:0] resp_i
);

  typedef enum logic [2:0] {IDLE, SEL, WAIT1, RD, WAIT2, STORE, PAUSE} state_t;

  localparam int PW = $clog2(PAUSE_CYCLES + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  state_t         state_q;
  logic [2:0]     cur_ch_q, ptr_q;
  logic           owner_req_q;
  logic [7:0]     mask_q, fresh_q;
  logic [11:0]    data_q, req_data_q;
  logic [11:0]    result_q [8];
  logic [PW-1:0]  pause_cnt_q;
  logic [TW-1:0]  tmo_cnt_q;
  logic [15:0]    cmd_q;
  logic           snd_q, req_ack_q, req_vld_q, scan_done_q, err_q;
  logic [2:0]     scan_next_d;
  logic           last_ch_d;
  logic [7:0]     above_d;
  logic           unused_resp;

  assign unused_resp = ^resp_i[15:12];

  // First enabled channel after the pointer; k=8 wraps back onto the pointer itself.
  always_comb begin
    scan_next_d = ptr_q;
    for (int k = 8; k >= 1; k--) begin
      if (ch_mask_i[ptr_q + 3'(k)]) scan_next_d = ptr_q + 3'(k);
    end
    above_d   = mask_q >> cur_ch_q;
    last_ch_d = (above_d[7:1] == 7'd0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cur_ch_q    <= '0;
      ptr_q       <= 3'd7;
      owner_req_q <= 1'b0;
      mask_q      <= '0;
      fresh_q     <= '0;
      data_q      <= '0;
      req_data_q  <= '0;
      pause_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      cmd_q       <= '0;
      snd_q       <= 1'b0;
      req_ack_q   <= 1'b0;
      req_vld_q   <= 1'b0;
      scan_done_q <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < 8; i++) result_q[i] <= '0;
    end else begin
      snd_q       <= 1'b0;
      req_ack_q   <= 1'b0;
      req_vld_q   <= 1'b0;
      scan_done_q <= 1'b0;
      case (state_q)
        IDLE, PAUSE: begin
          if (req_i) begin
            req_ack_q   <= 1'b1;
            cur_ch_q    <= req_ch_i;
            owner_req_q <= 1'b1;
            state_q     <= SEL;
          end else if (state_q == IDLE) begin
            if (en_i && ch_mask_i != 8'd0) begin
              cur_ch_q    <= scan_next_d;
              mask_q      <= ch_mask_i;
              owner_req_q <= 1'b0;
              state_q     <= SEL;
            end
          end else if (!en_i || pause_cnt_q == PAUSE_LAST) begin
            state_q <= IDLE;
          end else begin
            pause_cnt_q <= pause_cnt_q + 1'b1;
          end
        end
        SEL, RD: begin
          cmd_q     <= {2'b00, cur_ch_q, 11'h000};
          snd_q     <= 1'b1;
          tmo_cnt_q <= '0;
          state_q   <= (state_q == SEL) ? WAIT1 : WAIT2;
        end
        WAIT1, WAIT2: begin
          if (done_i) begin
            if (state_q == WAIT2) data_q <= resp_i[11:0];
            state_q <= (state_q == WAIT1) ? RD : STORE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        STORE: begin
          if (owner_req_q) begin
            req_data_q <= data_q;
            req_vld_q  <= 1'b1;
            state_q    <= IDLE;
          end else begin
            result_q[cur_ch_q] <= data_q;
            fresh_q[cur_ch_q]  <= 1'b1;
            ptr_q              <= cur_ch_q;
            if (last_ch_d) begin
              scan_done_q <= 1'b1;
              pause_cnt_q <= '0;
              state_q     <= (PAUSE_CYCLES == 0) ? IDLE : PAUSE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_data_o   = result_q[rd_ch_i];
  assign rd_fresh_o  = fresh_q[rd_ch_i];
  assign busy_o      = (state_q != IDLE) && (state_q != PAUSE);
  assign cmd_o       = cmd_q;
  assign snd_o       = snd_q;
  assign req_ack_o   = req_ack_q;
  assign req_vld_o   = req_vld_q;
  assign req_data_o  = req_data_q;
  assign scan_done_o = scan_done_q;
  assign err_o       = err_q;

endmodule

// File: doc/a2d_scan_ctrl.md
Name: a2d_scan_ctrl

Overview:
- Sequencer that owns the SPI monarch connected to the ADC128S 8-channel A2D.
- Round-robin scans the enabled channels and stores a 12-bit result per channel.
- Arbitrates one-shot channel reads from a single requester against the background scan.
- The ADC128S returns the conversion for the previous command, so every channel read is two SPI transactions (select, then read).

Parameters:
- PAUSE_CYCLES, 64: idle clocks between scan passes (0 = back-to-back).
- TIMEOUT, 4096: clocks allowed from snd to done before the transaction is declared failed.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  background scan enable
- ch_mask  in  8  per-channel scan enable, bit i = channel i
- req  in  1  one-shot read request, held until req_ack
- req_ch  in  3  channel for one-shot read, sampled when req_ack=1
- req_ack  out  1  one-cycle pulse, request accepted
- req_vld  out  1  one-cycle pulse, req_data valid
- req_data  out  12  one-shot result
- rd_ch  in  3  scan result readback select
- rd_data  out  12  stored result for rd_ch (combinational mux)
- rd_fresh  out  1  rd_ch result written since reset
- scan_done  out  1  one-cycle pulse at the end of each full pass
- err  out  1  sticky timeout flag, cleared only by rst
- busy  out  1  high in any state other than IDLE/PAUSE
- cmd  out  16  to SPI monarch: {2'b00, ch[2:0], 11'h000}
- snd  out  1  to SPI monarch: one-cycle start pulse
- done  in  1  from SPI monarch: one-cycle completion pulse
- resp  in  16  from SPI monarch: valid when done=1; result = resp[11:0]

Behaviour:
- Reset values: state IDLE, snd=0, cmd=0, req_ack=0, req_vld=0, req_data=0, scan_done=0, err=0, busy=0, all result registers 0, all fresh bits 0, scan pointer 7 (so the first pass starts at the lowest enabled channel).
- Reset is honoured in any state. Any in-flight done is ignored. The top level resets the SPI monarch on the same edge.
- States: IDLE, SEL, WAIT1, RD, WAIT2, STORE, PAUSE.
- IDLE arbitration, decided each cycle:
  - req=1 has priority: pulse req_ack, latch req_ch as cur_ch, set owner=REQ, go to SEL.
  - Else if en=1 and ch_mask!=0: cur_ch = next enabled channel after the scan pointer (wrapping 7->0), owner=SCAN, go to SEL.
  - Else stay in IDLE.
- SEL: drive cmd for cur_ch, pulse snd for 1 clk, go to WAIT1.
- WAIT1: wait for done, then go to RD. resp is discarded, since it belongs to the prior command.
- RD: identical cmd, snd pulse, go to WAIT2.
- WAIT2: on done, capture resp[11:0], go to STORE.
- cmd holds its value from SEL through WAIT2.
- Timeout: a counter runs in WAIT1/WAIT2. Reaching TIMEOUT sets err, drops the transaction (no store, no req_vld) and goes to IDLE. For owner=REQ, req_vld is not pulsed; the requester must re-request.
- STORE, owner=REQ: req_data=result, pulse req_vld. Scan pointer and results unchanged. Go to IDLE.
- STORE, owner=SCAN: write result[cur_ch], set fresh[cur_ch], scan pointer=cur_ch.
  - If no enabled channel is above cur_ch: pulse scan_done and go to PAUSE (or IDLE if PAUSE_CYCLES=0).
  - Otherwise go to IDLE.
- PAUSE: counts PAUSE_CYCLES clocks, then goes to IDLE.
  - req=1 aborts the pause immediately, same as the IDLE req path; the pause is not resumed.
  - en=0 also exits to IDLE.
- ch_mask or en changes take effect only at IDLE; an in-progress channel always completes. en=0 mid-pass leaves the pointer as is, and the pass resumes from there.
- Simultaneous events:
  - req arriving in STORE is served at the next IDLE cycle. Worst-case latency is one channel (2 SPI transactions).
  - done arriving in any state other than WAIT1/WAIT2 is ignored.
- rd_data/rd_fresh reflect a STORE write on the following cycle.

Test Plan:
- Reset, en=1, ch_mask=8'h05, bench SPI stub returns 16'h0A00|prev_ch:
  - Expect snd pairs with cmd=16'h0000 then 16'h1000.
  - rd_ch=0 -> rd_data=12'hA00; rd_ch=2 -> 12'hA02.
  - scan_done pulses once after channel 2; then 64 clocks with snd=0.
- req=1, req_ch=5 asserted mid-scan in WAIT1 of channel 0:
  - Channel 0 completes first.
  - req_ack pulses, then two snd with cmd=16'h2800; req_vld=1 with req_data=12'hA05.
  - Scan resumes at channel 2; result[5] and fresh[5] are untouched.
- req during PAUSE at count 10 -> req_ack the next cycle, pause abandoned, scan restarts at channel 0 after req_vld.
- Stub never returns done -> err=1 after 4096 clocks in WAIT1, state IDLE, no STORE. The next pass proceeds normally with err still 1.
- ch_mask=0, en=1 -> no snd over 1000 clocks, busy=0.
- rst=1 asserted during WAIT2 of channel 2:
  - Next cycle: snd=0, busy=0, all rd_data=0, rd_fresh=0, err=0.
  - The first post-reset cmd selects channel 0.
